// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch controller.
// Holds the address/instruction widths, reset vector, exception codes
// and the fetch FSM state encoding used by the controller and its bench.
package ifu_fetch_ctrl_pkg;

    localparam int DATA_W = 64;
    localparam int INST_W = 32;
    localparam int CNT_W  = 64;

    localparam logic [DATA_W-1:0] RESET_VECTOR = 64'h8000_0000;

    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_ACC  = 2'd1;
    localparam logic [1:0] EXC_MIS  = 2'd2;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    // Fetch targets must be 4-byte aligned; only the low two bits matter.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// Handshake bundle between the fetch controller, the instruction-memory
// port and decode. The controller uses the master view; the memory and
// decode side (or a bench) uses the slave view.
interface ifu_fetch_ctrl_if;
    import ifu_fetch_ctrl_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [DATA_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              imem_rsp_err;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_pc;
    logic [INST_W-1:0] out_inst;
    logic [1:0]        out_exc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output out_valid, out_pc, out_inst, out_exc,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  out_valid, out_pc, out_inst, out_exc,
        output out_ready
    );

endinterface

// File: rtl/ifu_perf_cnt.sv
// Fetch performance counters: delivered instructions and stall cycles.
// Both counters clear on reset and wrap silently.
module ifu_perf_cnt
    import ifu_fetch_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_fire_i,
    input  logic             stall_i,
    output logic [CNT_W-1:0] fetch_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // Count decode handshakes and stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fetch_fire_i) fetch_cnt_q <= fetch_cnt_q + 1'b1;
            if (stall_i)      stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: owns the architectural fetch PC, issues
// one instruction-memory request at a time, holds the returned instruction
// until decode takes it, and applies trap/branch redirects while squashing
// any in-flight fetch they make stale.
// Optional build macro IFU_PERF_CNT_EN adds perf_fetch_cnt/perf_stall_cnt.
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_valid,
    input  logic [DATA_W-1:0] trap_pc,
    input  logic              br_valid,
    input  logic [DATA_W-1:0] br_pc,
`ifdef IFU_PERF_CNT_EN
    output logic [CNT_W-1:0]  perf_fetch_cnt,
    output logic [CNT_W-1:0]  perf_stall_cnt,
`endif
    ifu_fetch_ctrl_if.master  bus
);

    fetch_state_e      state_q;
    logic [DATA_W-1:0] pc_q;
    logic              kill_q;
    logic [INST_W-1:0] inst_q;
    logic [1:0]        exc_q;

    logic              redir;
    logic [DATA_W-1:0] target;
    logic              tgt_mis;
    logic              req_fire;
    logic              out_fire;
    // Where fetch resumes once a discarded response has drained.
    logic [DATA_W-1:0] resume_pc_d;
    logic              resume_mis_d;

    // Redirect arbitration (trap beats branch) and handshake decode.
    always_comb begin
        redir        = trap_valid | br_valid;
        target       = trap_valid ? trap_pc : br_pc;
        tgt_mis      = misaligned(target[1:0]);
        req_fire     = bus.imem_req_valid & bus.imem_req_ready;
        out_fire     = bus.out_valid & bus.out_ready;
        resume_pc_d  = redir ? target : pc_q;
        resume_mis_d = misaligned(resume_pc_d[1:0]);
    end

    // Fetch sequencer: REQ issues, WAIT collects, HOLD presents to decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_VECTOR;
            kill_q  <= 1'b0;
            inst_q  <= '0;
            exc_q   <= EXC_NONE;
        end else begin
            case (state_q)
                REQ: begin
                    if (redir) begin
                        pc_q <= target;
                        if (req_fire) begin
                            // Request for the old PC is already out; drop its reply.
                            state_q <= WAIT;
                            kill_q  <= 1'b1;
                        end else if (tgt_mis) begin
                            state_q <= HOLD;
                            exc_q   <= EXC_MIS;
                            inst_q  <= '0;
                        end
                    end else if (req_fire) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if (redir || kill_q) begin
                            kill_q <= 1'b0;
                            pc_q   <= resume_pc_d;
                            if (resume_mis_d) begin
                                state_q <= HOLD;
                                exc_q   <= EXC_MIS;
                                inst_q  <= '0;
                            end else begin
                                state_q <= REQ;
                            end
                        end else begin
                            state_q <= HOLD;
                            exc_q   <= bus.imem_rsp_err ? EXC_ACC : EXC_NONE;
                            inst_q  <= bus.imem_rsp_err ? '0 : bus.imem_rsp_data;
                        end
                    end else if (redir) begin
                        pc_q   <= target;
                        kill_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redir) begin
                        pc_q <= target;
                        if (tgt_mis) begin
                            exc_q  <= EXC_MIS;
                            inst_q <= '0;
                        end else begin
                            state_q <= REQ;
                        end
                    end else if (out_fire) begin
                        pc_q    <= pc_q + DATA_W'(4);
                        state_q <= REQ;
                    end
                end
                default: begin
                    state_q <= REQ;
                    kill_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req_valid = ~rst & (state_q == REQ);
    assign bus.imem_req_addr  = pc_q;
    // A redirect squashes the held instruction in the same cycle.
    assign bus.out_valid      = ~rst & (state_q == HOLD) & ~redir;
    assign bus.out_pc         = pc_q;
    assign bus.out_inst       = inst_q;
    assign bus.out_exc        = exc_q;

`ifdef IFU_PERF_CNT_EN
    logic stall_cyc;
    assign stall_cyc = (state_q == WAIT) | ((state_q == REQ) & ~bus.imem_req_ready);

    ifu_perf_cnt u_perf_cnt (
        .clk          (clk),
        .rst          (rst),
        .fetch_fire_i (out_fire),
        .stall_i      (stall_cyc),
        .fetch_cnt_o  (perf_fetch_cnt),
        .stall_cnt_o  (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: directed scenarios plus a randomized run
// checked against a program-order model of the fetch PC.
module tb_ifu_fetch_ctrl;
    import ifu_fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap_valid = 1'b0;
    logic [63:0] trap_pc = '0;
    logic        br_valid = 1'b0;
    logic [63:0] br_pc = '0;
`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    ifu_fetch_ctrl_if bus_if();

    ifu_fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .trap_valid (trap_valid),
        .trap_pc    (trap_pc),
        .br_valid   (br_valid),
        .br_pc      (br_pc),
`ifdef IFU_PERF_CNT_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory model state
    int unsigned mem_rdy_pct = 100;
    int unsigned mem_lat_max = 0;
    int unsigned mem_err_mode = 0;
    logic        mem_pend = 1'b0;
    logic [63:0] mem_addr = '0;
    int unsigned mem_cnt = 0;
    logic        rst_drv = 1'b1;

    // per-cycle observations
    logic        obs_req_valid, obs_accept, obs_out_valid, obs_overlap;
    logic [63:0] obs_addr, obs_pc;
    logic [31:0] obs_inst;
    logic [1:0]  obs_exc;

    function automatic logic [31:0] mem_inst(input logic [63:0] a);
        return {a[23:2], 10'h013};
    endfunction

    function automatic logic mem_err(input logic [63:0] a);
        if (mem_err_mode == 2) return 1'b1;
        if (mem_err_mode == 1) return a[6:2] == 5'h1B;
        return 1'b0;
    endfunction

    function automatic logic [63:0] rand_aligned();
        return 64'h8000_0000 + (64'($urandom_range(1023)) << 2);
    endfunction

    function automatic logic [63:0] rand_target();
        int unsigned r;
        logic [63:0] t;
        r = $urandom_range(99);
        if (r < 5) t = 64'hFFFF_FFFF_FFFF_FFF0 + (64'($urandom_range(3)) << 2);
        else       t = rand_aligned();
        if (r >= 90) t[1:0] = 2'($urandom_range(3, 1));
        return t;
    endfunction

    // One clock cycle: drive inputs at negedge, observe #1 later, advance memory.
    task automatic cycle(input logic tv, input logic [63:0] tpc,
                         input logic bv, input logic [63:0] bpc, input logic ordy);
        logic rspv;
        @(negedge clk);
        rst        = rst_drv;
        trap_valid = tv;
        trap_pc    = tpc;
        br_valid   = bv;
        br_pc      = bpc;
        bus_if.out_ready      = ordy;
        rspv                  = mem_pend && (mem_cnt == 0);
        bus_if.imem_rsp_valid = rspv;
        bus_if.imem_rsp_data  = rspv ? mem_inst(mem_addr) : 32'h0;
        bus_if.imem_rsp_err   = rspv && mem_err(mem_addr);
        bus_if.imem_req_ready = ($urandom_range(99) < mem_rdy_pct);
        #1;
        obs_req_valid = bus_if.imem_req_valid;
        obs_addr      = bus_if.imem_req_addr;
        obs_accept    = bus_if.imem_req_valid && bus_if.imem_req_ready;
        obs_out_valid = bus_if.out_valid;
        obs_pc        = bus_if.out_pc;
        obs_inst      = bus_if.out_inst;
        obs_exc       = bus_if.out_exc;
        if (rspv) mem_pend = 1'b0;
        else if (mem_pend && mem_cnt != 0) mem_cnt = mem_cnt - 1;
        obs_overlap = obs_accept && mem_pend;
        if (obs_accept) begin
            mem_pend = 1'b1;
            mem_addr = obs_addr;
            mem_cnt  = $urandom_range(mem_lat_max);
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 64'h0, 1'b0, 64'h0, ordy);
    endtask

    task automatic do_reset();
        rst_drv = 1'b1;
        idle(1'b0);
        idle(1'b0);
        rst_drv  = 1'b0;
        mem_pend = 1'b0;
        mem_cnt  = 0;
        mem_rdy_pct = 100;
        mem_lat_max = 0;
        mem_err_mode = 0;
    endtask

    task automatic test_reset();
        rst_drv = 1'b1;
        idle(1'b1);
        checks++; if (obs_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", obs_req_valid); end
        checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", obs_out_valid); end
        idle(1'b1);
        rst_drv = 1'b0;
        mem_pend = 1'b0;
        idle(1'b1);
        checks++; if (obs_req_valid !== 1'b1) begin errors++; $display("FAIL rst_first_req got %b exp 1", obs_req_valid); end
        checks++; if (obs_addr !== 64'h8000_0000) begin errors++; $display("FAIL rst_first_addr got %h exp 80000000", obs_addr); end
        checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_out got %b exp 0", obs_out_valid); end
    endtask

    task automatic test_basic();
        do_reset();
        idle(1'b1);
        checks++; if (obs_accept !== 1'b1 || obs_addr !== 64'h8000_0000) begin errors++; $display("FAIL basic_req got %b/%h exp 1/80000000", obs_accept, obs_addr); end
        idle(1'b1);
        checks++; if (obs_out_valid !== 1'b0 || obs_req_valid !== 1'b0) begin errors++; $display("FAIL basic_wait got ov=%b rv=%b exp 0/0", obs_out_valid, obs_req_valid); end
        idle(1'b1);
        checks++; if (obs_out_valid !== 1'b1 || obs_pc !== 64'h8000_0000) begin errors++; $display("FAIL basic_out got %b/%h exp 1/80000000", obs_out_valid, obs_pc); end
        checks++; if (obs_inst !== 32'h0000_0013 || obs_exc !== 2'd0) begin errors++; $display("FAIL basic_inst got %h/%0d exp 00000013/0", obs_inst, obs_exc); end
        idle(1'b1);
        checks++; if (obs_req_valid !== 1'b1 || obs_addr !== 64'h8000_0004) begin errors++; $display("FAIL basic_next got %b/%h exp 1/80000004", obs_req_valid, obs_addr); end
    endtask

    task automatic test_branch_wait();
        do_reset();
        mem_lat_max = 2;
        idle(1'b1);
        mem_cnt = 2;
        mem_lat_max = 0;
        cycle(1'b0, 64'h0, 1'b1, 64'h8000_1000, 1'b1);
        checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL brw_redir_out got %b exp 0", obs_out_valid); end
        for (int i = 0; i < 2; i++) begin
            idle(1'b1);
            checks++; if (obs_out_valid !== 1'b0 || obs_req_valid !== 1'b0) begin errors++; $display("FAIL brw_killwait%0d got ov=%b rv=%b exp 0/0", i, obs_out_valid, obs_req_valid); end
        end
        idle(1'b1);
        checks++; if (obs_req_valid !== 1'b1 || obs_addr !== 64'h8000_1000) begin errors++; $display("FAIL brw_newreq got %b/%h exp 1/80001000", obs_req_valid, obs_addr); end
        idle(1'b1);
        idle(1'b1);
        checks++; if (obs_out_valid !== 1'b1 || obs_pc !== 64'h8000_1000 || obs_inst !== mem_inst(64'h8000_1000)) begin errors++; $display("FAIL brw_out got %b/%h/%h exp 1/80001000/%h", obs_out_valid, obs_pc, obs_inst, mem_inst(64'h8000_1000)); end
    endtask

    task automatic test_trap_br_hold();
        do_reset();
        idle(1'b1);
        idle(1'b1);
        cycle(1'b1, 64'h8000_0100, 1'b1, 64'h8000_2000, 1'b1);
        checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL tb_hold_squash got %b exp 0", obs_out_valid); end
        idle(1'b1);
        checks++; if (obs_req_valid !== 1'b1 || obs_addr !== 64'h8000_0100) begin errors++; $display("FAIL tb_hold_req got %b/%h exp 1/80000100", obs_req_valid, obs_addr); end
        idle(1'b1);
        idle(1'b1);
        checks++; if (obs_out_valid !== 1'b1 || obs_pc !== 64'h8000_0100) begin errors++; $display("FAIL tb_hold_out got %b/%h exp 1/80000100", obs_out_valid, obs_pc); end
    endtask

    task automatic test_backpressure();
        do_reset();
        idle(1'b0);
        idle(1'b0);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            checks++; if (obs_out_valid !== 1'b1 || obs_pc !== 64'h8000_0000 || obs_inst !== 32'h13 || obs_req_valid !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got ov=%b pc=%h inst=%h rv=%b exp 1/80000000/00000013/0", i, obs_out_valid, obs_pc, obs_inst, obs_req_valid); end
        end
        idle(1'b1);
        checks++; if (obs_out_valid !== 1'b1) begin errors++; $display("FAIL bp_fire got %b exp 1", obs_out_valid); end
        idle(1'b1);
        checks++; if (obs_req_valid !== 1'b1 || obs_addr !== 64'h8000_0004) begin errors++; $display("FAIL bp_next got %b/%h exp 1/80000004", obs_req_valid, obs_addr); end
    endtask

    task automatic test_errors();
        do_reset();
        mem_err_mode = 2;
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        checks++; if (obs_out_valid !== 1'b1 || obs_exc !== 2'd1 || obs_inst !== 32'h0) begin errors++; $display("FAIL err_acc got %b/%0d/%h exp 1/1/00000000", obs_out_valid, obs_exc, obs_inst); end
        do_reset();
        idle(1'b1);
        idle(1'b1);
        cycle(1'b0, 64'h0, 1'b1, 64'h8000_0002, 1'b1);
        checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL mis_squash got %b exp 0", obs_out_valid); end
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            checks++; if (obs_out_valid !== 1'b1 || obs_exc !== 2'd2 || obs_inst !== 32'h0 || obs_pc !== 64'h8000_0002) begin errors++; $display("FAIL mis_hold%0d got %b/%0d/%h/%h exp 1/2/00000000/80000002", i, obs_out_valid, obs_exc, obs_inst, obs_pc); end
            checks++; if (obs_req_valid !== 1'b0) begin errors++; $display("FAIL mis_noreq%0d got %b exp 0", i, obs_req_valid); end
        end
        cycle(1'b1, 64'h8000_0200, 1'b0, 64'h0, 1'b0);
        idle(1'b0);
        checks++; if (obs_req_valid !== 1'b1 || obs_addr !== 64'h8000_0200) begin errors++; $display("FAIL mis_escape got %b/%h exp 1/80000200", obs_req_valid, obs_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        cycle(1'b0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        idle(1'b1);
        checks++; if (obs_req_valid !== 1'b0 || obs_out_valid !== 1'b0) begin errors++; $display("FAIL wrap_kill got rv=%b ov=%b exp 0/0", obs_req_valid, obs_out_valid); end
        idle(1'b1);
        checks++; if (obs_req_valid !== 1'b1 || obs_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_req got %b/%h exp 1/fffffffffffffffc", obs_req_valid, obs_addr); end
        idle(1'b1);
        idle(1'b1);
        checks++; if (obs_out_valid !== 1'b1 || obs_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_out got %b/%h exp 1/fffffffffffffffc", obs_out_valid, obs_pc); end
        idle(1'b1);
        checks++; if (obs_req_valid !== 1'b1 || obs_addr !== 64'h0) begin errors++; $display("FAIL wrap_zero got %b/%h exp 1/0", obs_req_valid, obs_addr); end
    endtask

`ifdef IFU_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        idle(1'b1);
        checks++; if (perf_fetch_cnt !== 64'd0 || perf_stall_cnt !== 64'd0) begin errors++; $display("FAIL perf_reset got %0d/%0d exp 0/0", perf_fetch_cnt, perf_stall_cnt); end
        for (int i = 0; i < 29; i++) idle(1'b1);
        idle(1'b0);
        checks++; if (perf_fetch_cnt !== 64'd10) begin errors++; $display("FAIL perf_fetch got %0d exp 10", perf_fetch_cnt); end
        checks++; if (perf_stall_cnt !== 64'd10) begin errors++; $display("FAIL perf_stall got %0d exp 10", perf_stall_cnt); end
    endtask
`endif

    // Program-order model: the next instruction decode must see is at model_pc.
    task automatic test_random();
        logic [63:0] model_pc, tpc, bpc, exp_pc;
        logic        tv, bv, ordy, mis, seen_mis;
        logic [31:0] exp_inst;
        logic [1:0]  exp_exc;
        int unsigned r;
        int          delivered;
        do_reset();
        mem_rdy_pct  = 70;
        mem_lat_max  = 2;
        mem_err_mode = 1;
        model_pc  = RESET_VECTOR;
        seen_mis  = 1'b0;
        delivered = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            mis = (model_pc[1:0] != 2'b00);
            tv = 1'b0; bv = 1'b0; tpc = '0; bpc = '0;
            if (mis && seen_mis) begin
                tv  = 1'b1;
                tpc = rand_aligned();
            end else begin
                r   = $urandom_range(99);
                tv  = (r < 3);
                bv  = (r >= 2 && r < 7);
                tpc = rand_target();
                bpc = rand_target();
            end
            ordy = mis ? 1'b0 : ($urandom_range(99) < 60);
            cycle(tv, tpc, bv, bpc, ordy);
            checks++; if (obs_overlap !== 1'b0) begin errors++; $display("FAIL rnd_outstanding cyc %0d got 2 exp <=1", cyc); end
            checks++; if (obs_accept && obs_addr[1:0] !== 2'b00) begin errors++; $display("FAIL rnd_mis_req cyc %0d got addr %h exp aligned", cyc, obs_addr); end
            if (tv || bv) begin
                checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL rnd_squash cyc %0d got %b exp 0", cyc, obs_out_valid); end
                model_pc = tv ? tpc : bpc;
                seen_mis = 1'b0;
            end else begin
                if (obs_accept) begin
                    checks++; if (obs_addr !== model_pc) begin errors++; $display("FAIL rnd_req_addr cyc %0d got %h exp %h", cyc, obs_addr, model_pc); end
                end
                if (obs_out_valid) begin
                    exp_pc = model_pc;
                    if (mis) begin exp_exc = 2'd2; exp_inst = 32'h0; end
                    else if (mem_err(model_pc)) begin exp_exc = 2'd1; exp_inst = 32'h0; end
                    else begin exp_exc = 2'd0; exp_inst = mem_inst(model_pc); end
                    checks++; if (obs_pc !== exp_pc || obs_exc !== exp_exc || obs_inst !== exp_inst) begin errors++; $display("FAIL rnd_out cyc %0d got %h/%0d/%h exp %h/%0d/%h", cyc, obs_pc, obs_exc, obs_inst, exp_pc, exp_exc, exp_inst); end
                    if (ordy) begin
                        model_pc = model_pc + 64'd4;
                        delivered++;
                    end else if (mis) begin
                        seen_mis = 1'b1;
                    end
                end
            end
        end
        checks++; if (delivered < 100) begin errors++; $display("FAIL rnd_progress got %0d exp >=100", delivered); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.imem_req_ready = 1'b0;
        bus_if.imem_rsp_valid = 1'b0;
        bus_if.imem_rsp_data  = '0;
        bus_if.imem_rsp_err   = 1'b0;
        bus_if.out_ready      = 1'b0;
        test_reset();
        test_basic();
        test_branch_wait();
        test_trap_br_hold();
        test_backpressure();
        test_errors();
        test_wrap();
`ifdef IFU_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Sequences instruction fetch for the RV64 core and owns the architectural fetch PC.
- Issues one request at a time to the instruction-memory port and holds each returned instruction until decode accepts it.
- Applies trap and branch redirects, squashing any in-flight fetch the redirect makes stale.
- Replaces the simple PC register with a handshake-driven controller that tolerates multi-cycle memory latency.

Parameters:
- DATA_W, 64, address/PC width.
- INST_W, 32, instruction width.
- RESET_VECTOR, 64'h8000_0000, PC loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- trap_valid  in  1  trap/mret redirect request from CSR unit.
- trap_pc  in  DATA_W  trap target.
- br_valid  in  1  branch/jump redirect request from EXU.
- br_pc  in  DATA_W  branch target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  DATA_W  fetch address (= pc_q).
- imem_rsp_valid  in  1  response valid, one per accepted request.
- imem_rsp_data  in  INST_W  fetched instruction.
- imem_rsp_err  in  1  access fault on this response.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode consumes instruction.
- out_pc  out  DATA_W  PC of the presented instruction.
- out_inst  out  INST_W  instruction; 0 when out_exc != 0.
- out_exc  out  2  exception code: 0 none, 1 access fault, 2 misaligned target.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc_q=RESET_VECTOR, state=REQ, kill_q=0, held inst=0, exc=0.
  - imem_req_valid=0 and out_valid=0 are forced combinationally while rst=1.
- Redirect selection: redir = trap_valid | br_valid; target = trap_valid ? trap_pc : br_pc. Trap wins when both are asserted.
- Misaligned target: target[1:0] != 0.
  - Effect: pc_q<=target, state<=HOLD with exc=2, inst=0.
  - No memory request is issued for the misaligned target.
- State REQ:
  - imem_req_valid=1, addr=pc_q.
  - If imem_req_valid & imem_req_ready, go to WAIT.
  - A redirect in REQ (including in the accept cycle) overrides:
    - If the request was accepted in that cycle, go to WAIT with kill_q=1; otherwise stay in REQ.
    - pc_q<=target; the address changes the next cycle. The memory port does not require address stability before acceptance.
- State WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid with kill_q=1: discard the response, clear kill_q, go to REQ.
  - On imem_rsp_valid with kill_q=0: latch inst (or exc=1 and inst=0 if imem_rsp_err), go to HOLD.
  - Redirect in WAIT: pc_q<=target, kill_q<=1.
    - If imem_rsp_valid occurs in the same cycle, discard it, clear kill_q and go to REQ (or HOLD if the target is misaligned).
- State HOLD:
  - out_valid = ~redir (gated combinationally, so a redirect squashes the held instruction in the same cycle). out_pc=pc_q.
  - On out_valid & out_ready: pc_q<=pc_q+4 (mod 2^DATA_W, wraps), go to REQ.
  - Redirect in HOLD: pc_q<=target, go to REQ (or stay in HOLD with exc=2 if misaligned).
- Latency:
  - Redirect seen at edge N produces imem_req_valid with the new address in cycle N+1, unless a kill is pending.
  - With always-ready memory and next-cycle response, throughput is 1 instruction per 3 cycles.
- Ordering: at most one outstanding request; responses are never reordered.
- Reset mid-operation: any pending response after reset is a protocol violation. The memory side resets on the same rst.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- With the macro defined:
  - Adds output perf_fetch_cnt (64): counts out_valid & out_ready handshakes.
  - Adds output perf_stall_cnt (64): counts cycles in WAIT plus REQ cycles with ~imem_req_ready.
  - Both counters are cleared by rst and wrap.
- Without it: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package:
  - DATA_W and INST_W constants.
  - RESET_VECTOR.
  - Exception code constants (EXC_NONE=0, EXC_ACC=1, EXC_MIS=2).
  - FSM state encoding (REQ, WAIT, HOLD).
- Sub-module ifu_perf_cnt: the two counters, instantiated only under IFU_PERF_CNT_EN. Everything else is a single module.

Test Plan:
- Reset release, ready=1, 1-cycle response 0x00000013: first req addr 0x80000000; out_pc 0x80000000; next req 0x80000004.
- Branch redirect to 0x80001000 while in WAIT: the old response is discarded (no out_valid); the next req addr is 0x80001000.
- trap_valid (0x80000100) and br_valid (0x80002000) in the same cycle during HOLD: out_valid drops that cycle; the next req addr is 0x80000100.
- Backpressure: out_ready=0 for 5 cycles in HOLD keeps out_valid, out_pc and out_inst stable, with no new request; then one handshake advances PC by 4.
- imem_rsp_err=1 gives out_exc=1 and out_inst=0; br_pc=0x80000002 gives out_exc=2 with no imem request issued.
- pc_q=0xFFFF_FFFF_FFFF_FFFC consumed gives next req addr 0 (wrap). With IFU_PERF_CNT_EN, 10 fetches at 1/3 throughput give perf_fetch_cnt=10.
